// File: rtl/fulladder_bist_checker_pkg.sv
// Shared definitions for the full-adder BIST checker.
// Holds FSM state encodings, the vector count and the golden carry function.
// Imported by the checker top and by the reference full adder.
package fulladder_bist_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Exhaustive sweep of {a,b,cin}
  localparam int         NUM_VEC  = 8;
  localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

  // Majority of three: the carry-out of a correct full adder
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fulladder_ref.sv
// Golden full-adder model used by the BIST checker.
// Purely combinational, zero latency.
// No handshake; follows its inputs continuously.
module fulladder_ref
  import fulladder_bist_checker_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = maj3(a_i, b_i, cin_i);

endmodule

// File: rtl/fulladder_bist_checker.sv
// On-chip BIST for an attached full adder: sweeps all 8 input vectors and checks responses.
// done rises 8*(SETTLE_CYCLES+1) clocks after the edge that samples start.
// start is ignored while a sweep is running; held start in DONE restarts immediately.
module fulladder_bist_checker
  import fulladder_bist_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  output logic             cin_o,
  input  logic             sum_i,
  input  logic             cout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  // A one-cycle settle window still needs a 1-bit counter
  localparam int unsigned      CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_e             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [2:0]         ffvec_q, ffvec_d;
  logic               ffvalid_q, ffvalid_d;

  logic               exp_sum;
  logic               exp_cout;
  logic               mismatch;

  // Golden response is computed from the registered vector, so it matches what the DUT sees
  fulladder_ref u_ref (
    .a_i   (vec_q[2]),
    .b_i   (vec_q[1]),
    .cin_i (vec_q[0]),
    .sum_o (exp_sum),
    .cout_o(exp_cout)
  );

  // Case-inequality so that X/Z from a broken DUT is flagged rather than masked
  assign mismatch = (sum_i !== exp_sum) || (cout_i !== exp_cout);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start)            state_d = ST_SETTLE;
      ST_SETTLE:        if (cnt_q == '0)      state_d = ST_SAMPLE;
      ST_SAMPLE:        state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_SETTLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state and the registered error count only
  always_comb begin
    busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    done = (state_q == ST_DONE);
    pass = (state_q == ST_DONE) && (err_q == '0);
  end

  // Datapath next-state: vector stepping, settle countdown, error capture
  always_comb begin
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffvec_d   = ffvec_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d     = '0;
          cnt_d     = CNT_RELOAD;
          err_d     = '0;
          ffvec_d   = '0;
          ffvalid_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!ffvalid_q) begin
            ffvec_d   = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        // Last vector stays driven through DONE
        if (vec_q != LAST_VEC) begin
          vec_d = vec_q + 1'b1;
          cnt_d = CNT_RELOAD;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      ffvec_q   <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffvec_q   <= ffvec_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign a_o              = vec_q[2];
  assign b_o              = vec_q[1];
  assign cin_o            = vec_q[0];
  assign err_count        = err_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_fulladder_bist_checker.sv
// Bench for the full-adder BIST checker with a fault-injectable adder model.
// Expected sweep results are queued at start; a monitor pops them on each rising done.
// Second instance with a one-cycle settle window checks the stimulus cadence.
module tb_fulladder_bist_checker;

  typedef struct {
    int         done_cyc;
    logic       pass;
    logic [3:0] err;
    logic       ffvalid;
    logic [2:0] ffvec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic done_prev = 1'b0;
  logic [1:0] fault = 2'd0;

  // Main instance (SETTLE_CYCLES=4) with faulty-capable adder
  logic a, b, c, s, co;
  logic busy, done, pass, ffvalid;
  logic [3:0] err;
  logic [2:0] ffvec;

  // Second instance (SETTLE_CYCLES=1) with a good adder
  logic a1, b1, c1, s1, co1;
  logic busy1, done1, pass1, ffvalid1;
  logic [3:0] err1;
  logic [2:0] ffvec1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached full adder: 0 good, 1 cout stuck-at-0, 2 sum inverted
  always_comb begin
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    if (fault == 2'd1) co = 1'b0;
    if (fault == 2'd2) s = ~s;
  end

  assign s1  = a1 ^ b1 ^ c1;
  assign co1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

  fulladder_bist_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .a_o(a), .b_o(b), .cin_o(c), .sum_i(s), .cout_i(co),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_vec(ffvec), .first_fail_valid(ffvalid)
  );

  fulladder_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_o(a1), .b_o(b1), .cin_o(c1), .sum_i(s1), .cout_i(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffvec1), .first_fail_valid(ffvalid1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int dcyc, input logic p, input logic [3:0] e,
                          input logic fv, input logic [2:0] fvec);
    exp_t x;
    x.done_cyc = dcyc;
    x.pass     = p;
    x.err      = e;
    x.ffvalid  = fv;
    x.ffvec    = fvec;
    sb.push_back(x);
  endtask

  // Returns the cycle number of the negedge at which start was raised
  task automatic pulse_start(output int k);
    @(negedge clk);
    start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  // Scoreboard monitor: compare each completed sweep against the queued expectation
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_latency", cyc, mon_e.done_cyc);
        check("pass", pass, mon_e.pass);
        check("err_count", err, mon_e.err);
        check("first_fail_valid", ffvalid, mon_e.ffvalid);
        if (mon_e.ffvalid) check("first_fail_vec", ffvec, mon_e.ffvec);
      end
    end
    done_prev <= done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    int k2;

    // Reset state
    #1;
    check("reset_outputs", {busy, done, pass, err, ffvec, ffvalid, a, b, c}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, done, pass, err, ffvec, ffvalid, a, b, c}, 32'h0);

    // Good adder: done exactly 40 clocks after the sampling edge, pass
    fault = 2'd0;
    pulse_start(k);
    push_exp(k + 41, 1'b1, 4'd0, 1'b0, 3'd0);
    check("busy_in_sweep", busy, 1'b1);
    wait_done("t1_done", 100);
    repeat (3) @(negedge clk);
    check("done_held", {done, pass}, 2'b11);
    check("stim_held_111", {a, b, c}, 3'b111);

    // cout stuck-at-0: fails on 011, 101, 110, 111
    fault = 2'd1;
    pulse_start(k);
    push_exp(k + 41, 1'b0, 4'd4, 1'b1, 3'b011);
    wait_done("t2_done", 100);

    // sum inverted: every vector fails, first one is 000
    fault = 2'd2;
    pulse_start(k);
    push_exp(k + 41, 1'b0, 4'd8, 1'b1, 3'b000);
    wait_done("t3_done", 100);

    // start held high in DONE: restart on the next edge clears the results
    start = 1'b1;
    fault = 2'd0;
    k2 = cyc;
    push_exp(k2 + 41, 1'b1, 4'd0, 1'b0, 3'd0);
    @(negedge clk);
    start = 1'b0;
    check("restart_clear", {done, busy, err, ffvalid}, {1'b0, 1'b1, 4'd0, 1'b0});

    // start pulses while busy are ignored
    while (cyc < k2 + 5) @(negedge clk);
    start = 1'b1;
    check("busy_at_pulse5", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k2 + 20) @(negedge clk);
    start = 1'b1;
    check("busy_at_pulse20", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done("t5_done", 100);

    // Asynchronous reset mid-sweep, between edges at clock 17
    fault = 2'd2;
    pulse_start(k);
    while (cyc < k + 17) @(negedge clk);
    check("pre_reset_state", {busy, err, ffvalid, a, b, c}, {1'b1, 4'd3, 1'b1, 3'b011});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clear", {busy, done, pass, err, ffvec, ffvalid, a, b, c}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    fault = 2'd0;
    pulse_start(k);
    push_exp(k + 41, 1'b1, 4'd0, 1'b0, 3'd0);
    wait_done("t4_done", 100);

    // SETTLE_CYCLES=1: each vector held exactly two clocks
    @(negedge clk);
    start1 = 1'b1;
    k = cyc;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      start1 = 1'b0;
      check("stim_step", {a1, b1, c1}, 32'(j / 2));
    end
    @(negedge clk);
    check("short_sweep_done", {done1, pass1, err1, a1, b1, c1}, {1'b1, 1'b1, 4'd0, 3'b111});
    check("short_sweep_latency", cyc, k + 17);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
